// File: rtl/irq_pending_latch.sv
// Sticky rising-edge pending latch with a present/ack/gap handshake around an external priority encoder.
// Optional per-line masking of the pend vector is enabled by defining IRQ_PENDING_MASK_EN.
module irq_pending_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       clr_all,
`ifdef IRQ_PENDING_MASK_EN
  input  logic [3:0] mask,
`endif
  output logic [3:0] pend,
  input  logic [1:0] enc_id,
  input  logic       enc_valid,
  output logic [1:0] irq_id,
  output logic       irq_valid,
  input  logic       irq_ack,
  output logic [3:0] ovf
);

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t     state, state_nxt;
  logic [1:0] id_nxt;
  logic [3:0] req_d;
  logic [3:0] pnd;
  logic [3:0] req_edge;
  logic [3:0] ack_clr;

  assign req_edge = req & ~req_d;
  assign ack_clr  = (state == PRESENT && irq_ack) ? (4'b0001 << irq_id) : 4'b0000;

  // A same-cycle edge wins over the ack clear, so the bit stays pending and no overflow is flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_d <= 4'b0000;
      pnd   <= 4'b0000;
      ovf   <= 4'b0000;
    end else begin
      req_d <= req;
      if (clr_all) begin
        pnd <= 4'b0000;
        ovf <= 4'b0000;
      end else begin
        pnd <= (pnd & ~ack_clr) | req_edge;
        ovf <= ovf | (req_edge & pnd & ~ack_clr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      irq_id <= 2'd0;
    end else begin
      state  <= state_nxt;
      irq_id <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          state_nxt = PRESENT;
          id_nxt    = enc_id;
        end
      end
      PRESENT: begin
        if (irq_ack) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr_all) begin
      state_nxt = IDLE;
      id_nxt    = irq_id;
    end
  end

  assign irq_valid = (state == PRESENT);

`ifdef IRQ_PENDING_MASK_EN
  assign pend = pnd & ~mask;
`else
  assign pend = pnd;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomized and directed bench for irq_pending_latch, with a behavioural reference model and a bench-side priority encoder.
// Builds with or without IRQ_PENDING_MASK_EN.
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       clr_all;
  logic [3:0] mask;
  logic [3:0] pend;
  logic [1:0] enc_id;
  logic       enc_valid;
  logic [1:0] irq_id;
  logic       irq_valid;
  logic       irq_ack;
  logic [3:0] ovf;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state
  bit [3:0] mPend, mOvf, mPrevReq;
  bit       mHold;
  int       mCooldown;
  bit [1:0] mId;

  always #5 clk = ~clk;

  irq_pending_latch dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .clr_all(clr_all),
`ifdef IRQ_PENDING_MASK_EN
    .mask(mask),
`endif
    .pend(pend),
    .enc_id(enc_id),
    .enc_valid(enc_valid),
    .irq_id(irq_id),
    .irq_valid(irq_valid),
    .irq_ack(irq_ack),
    .ovf(ovf)
  );

  // Downstream 4:2 priority encoder, bit 3 highest
  always_comb begin
    enc_id    = 2'd0;
    enc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        enc_id    = 2'(i);
        enc_valid = 1'b1;
      end
    end
  end

  function automatic bit [3:0] visibleModel();
`ifdef IRQ_PENDING_MASK_EN
    return mPend & ~mask;
`else
    return mPend;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input bit [3:0] r, input bit c, input bit a, input bit rn);
    bit [3:0] vis;
    bit       ackHit;
    bit       clearing;
    int       best;
    vis = visibleModel();
    if (!rn) begin
      mPend = 0; mOvf = 0; mPrevReq = 0; mHold = 0; mCooldown = 0; mId = 0;
      return;
    end
    ackHit = mHold && a;
    if (c) begin
      mPend = 0; mOvf = 0; mHold = 0; mCooldown = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        clearing = ackHit && (i == int'(mId));
        if (r[i] && !mPrevReq[i]) begin
          if (mPend[i] && !clearing) mOvf[i] = 1'b1;
          mPend[i] = 1'b1;
        end else if (clearing) begin
          mPend[i] = 1'b0;
        end
      end
      if (mHold) begin
        if (a) begin
          mHold = 0;
          mCooldown = 1;
        end
      end else if (mCooldown > 0) begin
        mCooldown--;
      end else if (vis != 0) begin
        best = 0;
        for (int i = 0; i < 4; i++) if (vis[i]) best = i;
        mHold = 1;
        mId = 2'(best);
      end
    end
    mPrevReq = r;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic c, input logic a);
    req = r;
    clr_all = c;
    irq_ack = a;
    @(posedge clk);
    modelStep(r, c, a, rst_n);
    @(negedge clk);
    checkOutput("pend", 8'(pend), 8'(visibleModel()));
    checkOutput("ovf", 8'(ovf), 8'(mOvf));
    checkOutput("irq_valid", 8'(irq_valid), 8'(mHold));
    checkOutput("irq_id", 8'(irq_id), 8'(mId));
  endtask

  initial begin
    rst_n = 1'b0; req = 0; clr_all = 0; irq_ack = 0; mask = 0;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("resetPend", 8'(pend), 8'h0);
    checkOutput("resetValid", 8'(irq_valid), 8'h0);
    rst_n = 1'b1;

    // Single pulse on bit 2, held without ack
    applyStimulus(4'b0100, 0, 0);
    checkOutput("pulsePend", 8'(pend), 8'h4);
    checkOutput("pulseNotYetValid", 8'(irq_valid), 8'h0);
    applyStimulus(0, 0, 0);
    checkOutput("pulseValid", 8'(irq_valid), 8'h1);
    checkOutput("pulseId", 8'(irq_id), 8'h2);
    repeat (10) applyStimulus(0, 0, 0);
    checkOutput("heldId", 8'(irq_id), 8'h2);
    applyStimulus(0, 0, 1);
    checkOutput("gapLow", 8'(irq_valid), 8'h0);
    applyStimulus(0, 0, 0);

    // Simultaneous edges on bits 0 and 3
    applyStimulus(4'b1001, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("dualFirstId", 8'(irq_id), 8'h3);
    applyStimulus(0, 0, 1);
    checkOutput("dualGap", 8'(irq_valid), 8'h0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("dualSecondId", 8'(irq_id), 8'h0);
    checkOutput("dualSecondValid", 8'(irq_valid), 8'h1);
    applyStimulus(0, 0, 1);
    checkOutput("dualDrained", 8'(pend), 8'h0);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("dualIdle", 8'(irq_valid), 8'h0);

    // Higher priority edge while presenting ID 1
    applyStimulus(4'b0010, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(4'b1000, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("frozenId", 8'(irq_id), 8'h1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("nextId", 8'(irq_id), 8'h3);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Overflow, then edge coinciding with its own ack
    applyStimulus(4'b0100, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(4'b0100, 0, 0);
    checkOutput("ovfSet", 8'(ovf), 8'h4);
    applyStimulus(0, 0, 0);
    applyStimulus(4'b0100, 0, 1);
    checkOutput("setWinsPend", 8'(pend[2]), 8'h1);
    checkOutput("setWinsOvf", 8'(ovf), 8'h4);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("represent", 8'(irq_id), 8'h2);

    // clr_all together with ack, then reset mid-present
    applyStimulus(4'b1010, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("clrPend", 8'(pend), 8'h0);
    checkOutput("clrOvf", 8'(ovf), 8'h0);
    checkOutput("clrValid", 8'(irq_valid), 8'h0);
    applyStimulus(4'b0100, 0, 0);
    applyStimulus(0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("rstValid", 8'(irq_valid), 8'h0);
    checkOutput("rstId", 8'(irq_id), 8'h0);
    rst_n = 1'b1;

`ifdef IRQ_PENDING_MASK_EN
    mask = 4'b1000;
    applyStimulus(4'b1000, 0, 0);
    checkOutput("maskedPend", 8'(pend), 8'h0);
    applyStimulus(0, 0, 0);
    checkOutput("maskedNoValid", 8'(irq_valid), 8'h0);
    mask = 4'b0000;
    applyStimulus(0, 0, 0);
    checkOutput("unmaskId", 8'(irq_id), 8'h3);
    checkOutput("unmaskValid", 8'(irq_valid), 8'h1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 1) == 0) ? req : 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 99) != 0);
`ifdef IRQ_PENDING_MASK_EN
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
`endif
      applyStimulus(r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
